// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: hazards, MUL/DIV occupancy and memory wait.
// Optional STALL_CNT_EN builds the saturating stall performance counter; otherwise stall_cnt is 0.
module pipe_stall_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             d_loaddepen,
  input  logic             d_branch,
  input  logic             mdu_start,
  input  logic             mem_busy,
  output logic             wpcir,
  output logic             id_bubble,
  output logic             if_flush,
  output logic             pipe_en,
  output logic             mdu_busy,
  output logic [3:0]       mdu_cnt,
  output logic             state,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MDU_WAIT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= ST_RUN;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Priority: mem_busy > MDU_WAIT > load-use > mdu_start > branch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    wpcir       = 1'b1;
    id_bubble   = 1'b0;
    if_flush    = 1'b0;
    pipe_en     = 1'b1;
    if (!clrn) begin
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = 4'd0;
    end else if (mem_busy) begin
      wpcir   = 1'b0;
      pipe_en = 1'b0;
    end else if (r_state == ST_MDU_WAIT) begin
      wpcir     = 1'b0;
      id_bubble = 1'b1;
      if (r_cnt == 4'd1) begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = 4'd0;
      end else begin
        w_cnt_nxt = r_cnt - 4'd1;
      end
    end else if (d_loaddepen) begin
      wpcir     = 1'b0;
      id_bubble = 1'b1;
    end else if (mdu_start) begin
      if (MDU_LAT > 1) begin
        w_state_nxt = ST_MDU_WAIT;
        w_cnt_nxt   = 4'(MDU_LAT - 1);
      end
    end else if (d_branch) begin
      if_flush = 1'b1;
    end
  end

  assign mdu_busy = (r_state == ST_MDU_WAIT);
  assign mdu_cnt  = r_cnt;
  assign state    = r_state;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_stall_cnt <= '0;
    end else if (!wpcir && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Randomized + directed bench for pipe_stall_ctrl against a cycle-level behavioural model.
// Honours STALL_CNT_EN for the expected stall counter.
module tb_pipe_stall_ctrl;

  localparam int LAT   = 4;
  localparam int CW    = 4;
  localparam int SMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          clrn;
  logic          d_loaddepen, d_branch, mdu_start, mem_busy;
  logic          wpcir, id_bubble, if_flush, pipe_en, mdu_busy, state;
  logic [3:0]    mdu_cnt;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // model: remaining MDU wait cycles (0 means RUN) and stall count
  int m_wait;
  int m_stall;

  pipe_stall_ctrl #(.MDU_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .clrn(clrn),
    .d_loaddepen(d_loaddepen), .d_branch(d_branch),
    .mdu_start(mdu_start), .mem_busy(mem_busy),
    .wpcir(wpcir), .id_bubble(id_bubble), .if_flush(if_flush),
    .pipe_en(pipe_en), .mdu_busy(mdu_busy), .mdu_cnt(mdu_cnt),
    .state(state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // mdu_start together with d_branch is a decoder error
  assert property (@(posedge clk) disable iff (!clrn) !(mdu_start && d_branch));

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_stall();
`ifdef STALL_CNT_EN
    return m_stall;
`else
    return 0;
`endif
  endfunction

  // one pipeline cycle: drive, check at negedge, advance model, step past posedge
  task automatic cycle(input logic ld, input logic br, input logic ms, input logic mb);
    int e_wp, e_bub, e_fl, e_pe;
    d_loaddepen = ld; d_branch = br; mdu_start = ms; mem_busy = mb;
    @(negedge clk);
    e_wp = 1; e_bub = 0; e_fl = 0; e_pe = 1;
    if (mb) begin
      e_wp = 0; e_pe = 0;
    end else if (m_wait > 0) begin
      e_wp = 0; e_bub = 1;
    end else if (ld) begin
      e_wp = 0; e_bub = 1;
    end else if (!ms && br) begin
      e_fl = 1;
    end
    check("wpcir",     int'(wpcir),     e_wp);
    check("id_bubble", int'(id_bubble), e_bub);
    check("if_flush",  int'(if_flush),  e_fl);
    check("pipe_en",   int'(pipe_en),   e_pe);
    check("mdu_busy",  int'(mdu_busy),  (m_wait > 0) ? 1 : 0);
    check("state",     int'(state),     (m_wait > 0) ? 1 : 0);
    check("mdu_cnt",   int'(mdu_cnt),   m_wait);
    check("stall_cnt", int'(stall_cnt), exp_stall());
    if (e_wp == 0 && m_stall < SMAX) m_stall++;
    if (!mb) begin
      if (m_wait > 0) m_wait--;
      else if (!ld && ms && LAT > 1) m_wait = LAT - 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    d_loaddepen = 0; d_branch = 0; mdu_start = 0; mem_busy = 0;
    clrn = 1'b0;
    @(posedge clk);
    #1;
    clrn = 1'b1;
    m_wait = 0; m_stall = 0;
  endtask

  initial begin
    m_wait = 0; m_stall = 0;
    do_reset();

    // async reset in the middle of an MDU wait
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    #2;
    clrn = 1'b0;
    #1;
    check("rst_state",   int'(state),     0);
    check("rst_mdu_cnt", int'(mdu_cnt),   0);
    check("rst_wpcir",   int'(wpcir),     1);
    check("rst_pipe_en", int'(pipe_en),   1);
    check("rst_busy",    int'(mdu_busy),  0);
    check("rst_stall",   int'(stall_cnt), 0);
    @(posedge clk);
    #1;
    clrn = 1'b1;
    m_wait = 0; m_stall = 0;
    cycle(0, 0, 0, 0);

    // load-use stall
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // MDU occupancy: 3 stall cycles counting 3,2,1
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
    check("mdu_done_state", int'(state), 0);

    // mem_busy freezes the wait at mdu_cnt=2
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    check("freeze_cnt_pre", int'(mdu_cnt), 2);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    check("freeze_cnt_post", int'(mdu_cnt), 2);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("freeze_exit", int'(state), 0);

    // branch under load-use gives a bubble only, then flushes alone
    cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);

    // saturation of the stall counter
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1, 0, 0, 0);
    @(negedge clk);
`ifdef STALL_CNT_EN
    check("stall_sat", int'(stall_cnt), SMAX);
`else
    check("stall_sat", int'(stall_cnt), 0);
`endif
    @(posedge clk);
    #1;

    // randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic ld, br, ms, mb;
      ld = ($urandom_range(0, 99) < 20);
      mb = ($urandom_range(0, 99) < 15);
      ms = ($urandom_range(0, 99) < 15);
      br = !ms && ($urandom_range(0, 99) < 25);
      cycle(ld, br, ms, mb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
